// File: rtl/tts_pkg.sv
// tts_pkg: shared state encoding and limits for the truth-table sweeper
package tts_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} tts_state_t;
   localparam int SETTLE_W   = 4;
   localparam int N_IN_MAX   = 8;
   localparam int SETTLE_MAX = 15;
endpackage

// File: rtl/tts_settle_timer.sv
// tts_settle_timer: loadable down-counter, expire flags the last settle cycle
module tts_settle_timer
   import tts_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [SETTLE_W-1:0] val,
   output logic                expire
);
   logic [SETTLE_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign expire = cnt == SETTLE_W'(1);
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector, compares against a golden mask;
// define TTS_CAPTURE_EN to record sampled outputs on observed
module truth_table_sweeper
   import tts_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [2**N_IN-1:0] golden,
   input  logic               dut_out,
   output logic [N_IN-1:0]    dut_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [N_IN:0]      err_count,
   output logic [N_IN-1:0]    first_err_idx,
   output logic [2**N_IN-1:0] observed
);
   if (N_IN < 1 || N_IN > N_IN_MAX || SETTLE < 0 || SETTLE > SETTLE_MAX) begin : g_bad_cfg
      $error("truth_table_sweeper: N_IN or SETTLE out of range");
   end
   localparam tts_state_t VEC_ST = (SETTLE == 0) ? SAMPLE : WAIT;
   tts_state_t state, nxt;
   logic [N_IN-1:0] idx;
   logic accept, load, expire, last, mis;
   assign accept = start && (state == IDLE || state == DONE);
   assign last   = &idx;
   assign mis    = dut_out != golden[idx];
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = start ? VEC_ST : IDLE;
         WAIT:    nxt = expire ? SAMPLE : WAIT;
         SAMPLE:  nxt = last ? DONE : VEC_ST;
         DONE:    nxt = start ? VEC_ST : IDLE;
         default: nxt = IDLE;
      endcase
      load = nxt == WAIT && state != WAIT;
   end
   tts_settle_timer u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .val    (SETTLE_W'(SETTLE)),
      .expire (expire)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         idx           <= '0;
         err_count     <= '0;
         first_err_idx <= '0;
         pass          <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            idx           <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            pass          <= 1'b0;
         end else if (state == SAMPLE) begin
            if (mis) err_count <= err_count + 1'b1;
            if (mis && err_count == '0) first_err_idx <= idx;
            if (!last) idx <= idx + 1'b1;
            else pass <= err_count == '0 && !mis;
         end
      end
`ifdef TTS_CAPTURE_EN
   logic [2**N_IN-1:0] cap;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cap <= '0;
      else if (accept) cap <= '0;
      else if (state == SAMPLE) cap[idx] <= dut_out;
   assign observed = cap;
`else
   assign observed = '0;
`endif
   assign dut_in = idx;
   assign busy   = state == WAIT || state == SAMPLE;
   assign done   = state == DONE;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench over three sweeper configurations
module tb_truth_table_sweeper;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, bmode = 1'b0;
   logic [15:0] golden = '0;
   int sel = 0;
   int n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;

   logic [2:0] in_a; logic [3:0] in_b; logic [0:0] in_c;
   logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
   logic [3:0] err_a; logic [4:0] err_b; logic [1:0] err_c;
   logic [2:0] fe_a; logic [3:0] fe_b; logic [0:0] fe_c;
   logic [7:0] obs_a; logic [15:0] obs_b; logic [1:0] obs_c;
   logic st_a, st_b, st_c, y_a, y_b, y_c;
   assign st_a = start && sel == 0;
   assign st_b = start && sel == 1;
   assign st_c = start && sel == 2;
   assign y_a = (in_a[2] & in_a[1]) | (in_a[2] & in_a[0]) | (in_a[1] & in_a[0]);
   assign y_b = bmode ? ^in_b : 1'b1;
   assign y_c = ~in_c[0];

   truth_table_sweeper #(.N_IN(3), .SETTLE(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(st_a), .golden(golden[7:0]), .dut_out(y_a),
      .dut_in(in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_a), .first_err_idx(fe_a), .observed(obs_a));
   truth_table_sweeper #(.N_IN(4), .SETTLE(2)) u_b (
      .clk(clk), .rst_n(rst_n), .start(st_b), .golden(golden), .dut_out(y_b),
      .dut_in(in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_b), .first_err_idx(fe_b), .observed(obs_b));
   truth_table_sweeper #(.N_IN(1), .SETTLE(1)) u_c (
      .clk(clk), .rst_n(rst_n), .start(st_c), .golden(golden[1:0]), .dut_out(y_c),
      .dut_in(in_c), .busy(busy_c), .done(done_c), .pass(pass_c),
      .err_count(err_c), .first_err_idx(fe_c), .observed(obs_c));

   logic busy_s, done_s, pass_s;
   logic [7:0] in_s, fe_s;
   logic [8:0] err_s;
   logic [15:0] obs_s;
   assign busy_s = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
   assign done_s = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
   assign pass_s = sel == 0 ? pass_a : sel == 1 ? pass_b : pass_c;
   assign in_s   = sel == 0 ? 8'(in_a) : sel == 1 ? 8'(in_b) : 8'(in_c);
   assign fe_s   = sel == 0 ? 8'(fe_a) : sel == 1 ? 8'(fe_b) : 8'(fe_c);
   assign err_s  = sel == 0 ? 9'(err_a) : sel == 1 ? 9'(err_b) : 9'(err_c);
   assign obs_s  = sel == 0 ? 16'(obs_a) : sel == 1 ? 16'(obs_b) : 16'(obs_c);

   typedef struct {int err; int first; logic pass; logic [15:0] obs; int lat;} exp_t;
   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s sel=%0d got=%0h exp=%0h", tag, sel, got, exp);
   endtask

   function automatic logic model_y(input int s, input int i);
      logic [3:0] v;
      v = 4'(i);
      if (s == 0) return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      if (s == 1) return bmode ? ^v : 1'b1;
      return ~v[0];
   endfunction

   task automatic kick(input logic [15:0] g);
      exp_t e;
      int n_in, settle;
      logic y;
      n_in = sel == 0 ? 3 : sel == 1 ? 4 : 1;
      settle = sel == 0 ? 0 : sel == 1 ? 2 : 1;
      e.err = 0; e.first = 0; e.obs = '0;
      for (int i = 0; i < (1 << n_in); i++) begin
         y = model_y(sel, i);
         e.obs[i] = y;
         if (y != g[i]) begin
            if (e.err == 0) e.first = i;
            e.err++;
         end
      end
      e.pass = e.err == 0;
      e.lat = (1 << n_in) * (settle + 1);
      sb.push_back(e);
      golden = g;
      start = 1'b1;
   endtask

   task automatic wait_done(input bit repulse);
      exp_t e;
      int n;
      @(posedge clk); #1 start = 1'b0;
      check("acc_busy", busy_s, 1);
      check("acc_in", in_s, 0);
      check("acc_err", err_s, 0);
      check("acc_done", done_s, 0);
      for (n = 1; n <= 200; n++) begin
         @(posedge clk); #1 start = 1'b0;
         if (repulse && n == 5) start = 1'b1;
         if (sel == 0 && n < 8) check("seq_in", in_s, n);
         if (done_s) break;
      end
      start = 1'b0;
      if (!done_s) check("timeout", 0, 1);
      e = sb.pop_front();
      check("latency", n, e.lat);
      check("err_count", err_s, e.err);
      if (e.err != 0) check("first_err", fe_s, e.first);
      check("pass", pass_s, e.pass);
      check("busy_done", busy_s, 0);
`ifdef TTS_CAPTURE_EN
      check("observed", obs_s, e.obs);
`else
      check("observed", obs_s, 0);
`endif
   endtask

   task automatic idle_check(input int last_in);
      @(posedge clk); #1;
      check("done_pulse", done_s, 0);
      check("idle_busy", busy_s, 0);
      check("hold_in", in_s, last_in);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy_s, 0);
      check("rst_done", done_s, 0);
      check("rst_pass", pass_s, 0);
      check("rst_err", err_s, 0);
      check("rst_in", in_s, 0);
      check("rst_obs", obs_s, 0);
      @(negedge clk) rst_n = 1'b1;
      sel = 0;
      @(negedge clk) kick(16'h00E9);
      wait_done(0);
      kick(16'h00E8);
      wait_done(0);
      idle_check(7);
      sel = 1;
      @(negedge clk) bmode = 1'b0;
      kick(16'h00FF);
      wait_done(1);
      idle_check(15);
      @(negedge clk) bmode = 1'b1;
      kick(16'h6996);
      wait_done(0);
      idle_check(15);
      @(negedge clk) kick(16'h6996);
      @(posedge clk); #1 start = 1'b0;
      for (int n = 0; n < 100 && in_s != 5; n++) begin
         @(posedge clk); #1;
      end
      check("rst_reach", in_s, 5);
      rst_n = 1'b0;
      #1;
      check("arst_busy", busy_s, 0);
      check("arst_pass", pass_s, 0);
      check("arst_err", err_s, 0);
      check("arst_in", in_s, 0);
      check("arst_obs", obs_s, 0);
      sb.delete();
      repeat (3) @(posedge clk);
      #1 check("arst_nodone", done_s, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) kick(16'h6996);
      wait_done(0);
      sel = 2;
      @(negedge clk) kick(16'h0001);
      wait_done(0);
      idle_check(1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Self-checking truth-table sequencer for the lab's combinational exercise modules. It replaces hand-written per-table stimulus blocks with one parametrised engine. On `start` it drives all 2^N_IN input combinations onto a combinational DUT in ascending order, waits a programmable settle time, and samples the DUT output. It compares each sample against a golden minterm mask and reports a mismatch count, the first failing index and a pass flag.

## Interface
- `N_IN`, 4: number of DUT inputs, range 1..8; vector index `i` drives `dut_in = i`, MSB = variable A.
- `SETTLE`, 1: idle cycles between applying a vector and sampling it, range 0..15.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a sweep; honoured only in IDLE or DONE.
- `golden` input 2^N_IN: expected output; bit `i` = expected Y for vector `i`; sampled every compare, must be held stable during a sweep.
- `dut_out` input 1: DUT output Y.
- `dut_in` output N_IN: vector applied to the DUT.
- `busy` output 1: high from the accepted `start` until the last sample.
- `done` output 1: one-cycle pulse after the last sample.
- `pass` output 1: 1 when the last completed sweep had zero mismatches.
- `err_count` output N_IN+1: mismatches in the last or current sweep, saturates impossible (max 2^N_IN fits).
- `first_err_idx` output N_IN: index of the first mismatch; meaningful only when `err_count != 0`.
- `observed` output 2^N_IN: sampled DUT outputs per index (see Configuration).

## Operation
- States:
  - IDLE
  - WAIT (settle countdown)
  - SAMPLE (compare)
  - DONE
- Transitions:
  - IDLE/DONE + `start` -> WAIT, or -> SAMPLE directly when `SETTLE == 0`.
    - On entry: clear `idx`, `err_count`, `first_err_idx`, `observed` and `pass`; set `busy`.
  - WAIT: settle counter loaded with `SETTLE`, decrements each cycle; at 1 -> SAMPLE.
  - SAMPLE: compare `dut_out` vs `golden[idx]`.
    - On mismatch, increment `err_count`; if `err_count` was 0, load `first_err_idx = idx`.
    - If `idx == 2^N_IN-1` -> DONE, else `idx++` and return to WAIT (or SAMPLE if `SETTLE == 0`).
  - DONE: `done = 1`, `busy = 0`, `pass = (err_count == 0)` registered on entry. Next cycle -> IDLE unless `start`, which restarts.
- `start` while in WAIT or SAMPLE is ignored; no restart, no error.
- `dut_in` is always driven from `idx` and holds the last vector (2^N_IN-1) after the sweep until the next start.
- `dut_out` is compared as a 2-state value; X/Z handling is the bench's concern.
- Reset values: all outputs 0, state IDLE, `idx` 0.
- Reset asserted mid-sweep aborts immediately to those values; no `done` pulse.

## Timing
- Each vector occupies SETTLE+1 cycles: SETTLE in WAIT, 1 in SAMPLE. `dut_out` is captured on the rising edge that ends SAMPLE.
- `start` sampled high at edge k: `busy` and `dut_in = 0` are visible after edge k.
- The first compare occurs at edge k+SETTLE+1.
- The last compare occurs at edge k + 2^N_IN*(SETTLE+1). `done` is high for the following cycle, and `pass` is valid from the same edge.
- Default parameters: a 16-vector sweep completes 32 cycles after `start`.
- The DUT has SETTLE+1 cycles of combinational settling per vector; SETTLE=0 gives one full cycle.

## Configuration
- `TTS_CAPTURE_EN` defined:
  - A 2^N_IN-bit register records `dut_out` at each SAMPLE into bit `idx`.
  - The register is cleared at `start`, and `observed` shows it.
- Not defined:
  - No capture register is built; `observed` is tied to 0.
  - All other behaviour is identical.

## Structure
- Package `tts_pkg`:
  - state enum `tts_state_t` {IDLE, WAIT, SAMPLE, DONE}
  - `SETTLE_W = 4`
  - limit constants `N_IN_MAX = 8`, `SETTLE_MAX = 15`
- Sub-module `tts_settle_timer`: loadable down-counter with a `load`/`expire` interface. The top keeps the FSM, index counter and scoreboard registers.

## Test plan
- N_IN=3, SETTLE=0, DUT = majority(A,B,C), `golden = 8'b1110_1000`, one `start`:
  - `dut_in` sequences 0..7, one per cycle.
  - `done` pulses 8 cycles after `start`, with `pass=1` and `err_count=0`.
  - With the macro, `observed = 8'hE8`.
- Same DUT, `golden = 8'b1110_1001` (bit 0 wrong):
  - `err_count=1`, `first_err_idx=0`, `pass=0`.
- N_IN=4, SETTLE=2, DUT output stuck at 1, `golden = 16'h00FF`:
  - `err_count=8`, `first_err_idx=8`.
  - `done` arrives exactly 48 cycles after `start`.
- `start` re-pulsed at cycle 5 of a sweep: ignored, and completion timing is unchanged. `start` asserted during the `done` cycle: a new sweep begins with counters cleared.
- `rst_n` low at vector 5 mid-sweep:
  - All outputs return to 0 asynchronously, with no `done`.
  - After release, a `start` runs a full clean sweep.
- N_IN=1 with an inverter and `golden = 2'b01`: `pass=1` after 2*(SETTLE+1) cycles. Without `TTS_CAPTURE_EN`, `observed` stays 0.
